// File: rtl/seg_pkg.sv
// Shared types, constants and leading-zero helper for the 7-segment scan path.
// Latency: none (types and a pure combinational function only).
// Backpressure: not applicable.
package seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Code the downstream decoder renders as an unlit digit.
    localparam bcd_digit_t BLANK_CODE = 4'hF;

    // Widest display supported; narrower displays zero-extend into this.
    localparam int MAX_DIGITS = 8;

    // Bit k set when digit k (k>0) and every more significant digit are zero.
    // Digit 0 is never marked so an all-zero value still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] value,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  nonzero_above;
        mask          = '0;
        nonzero_above = 1'b0;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < num_digits) begin
                if (value[4*k +: 4] != 4'h0) begin
                    nonzero_above = 1'b1;
                end
                mask[k] = (k != 0) && !nonzero_above;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/refresh_divider.sv
// Digit-slot timer: counts REFRESH_DIV cycles per slot, flags slot end and lit start.
// Latency: strobes are combinational from the counter register (valid the cycle before the edge they mark).
// Backpressure: none; free-running from reset.
module refresh_divider #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic lit_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Next count; slot_end marks the wrap edge, lit_start the edge reaching BLANK_CYCLES.
    always_comb begin
        slot_end  = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
        div_cnt_d = slot_end ? '0 : div_cnt_q + CNT_W'(1);
        lit_start = (div_cnt_d == CNT_W'(BLANK_CYCLES));
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan: shadow/active BCD frame buffering, digit select, anode drive, LZ blanking.
// Latency: num_out/anode_n registered; a load shows at the next frame commit (same-cycle load bypasses shadow).
// Backpressure: none; load is a fire-and-forget strobe, last load before commit wins.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank_lz,
    output logic [3:0]              num_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  slot_end;
    logic                  lit_start;
    logic                  commit;

    logic [W-1:0]          shadow_q;
    logic [W-1:0]          shadow_d;
    logic [W-1:0]          active_q;
    logic [W-1:0]          active_d;
    logic [IDX_W-1:0]      index_q;
    logic [IDX_W-1:0]      index_d;
    bcd_digit_t            num_out_q;
    bcd_digit_t            num_out_d;
    logic [NUM_DIGITS-1:0] anode_n_q;
    logic [NUM_DIGITS-1:0] anode_n_d;
    logic                  frame_done_q;
    logic                  frame_done_d;

    logic [4*MAX_DIGITS-1:0] frame_ext;
    logic [MAX_DIGITS-1:0]   blank_mask;
    bcd_digit_t              sel_digit;
    logic                    sel_blank;

    refresh_divider #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_end  (slot_end),
        .lit_start (lit_start)
    );

    // Shadow capture: last load wins, no handshake back to the SPI side.
    always_comb begin
        shadow_d = load ? bcd_in : shadow_q;
    end

    // Slot sequencing and frame commit; a load on the commit cycle goes straight to active.
    always_comb begin
        commit       = slot_end && (index_q == LAST_IDX);
        index_d      = index_q;
        active_d     = active_q;
        frame_done_d = commit;
        if (slot_end) begin
            index_d = commit ? '0 : index_q + IDX_W'(1);
        end
        if (commit) begin
            active_d = load ? bcd_in : shadow_q;
        end
    end

    // Digit code for the slot being entered, taken from the frame that slot will display.
    always_comb begin
        frame_ext            = '0;
        frame_ext[W-1:0]     = active_d;
        blank_mask           = lz_mask(frame_ext, NUM_DIGITS);
        sel_digit            = '0;
        sel_blank            = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_d == IDX_W'(k)) begin
                sel_digit = active_d[4*k +: 4];
                sel_blank = blank_mask[k];
            end
        end
        num_out_d = num_out_q;
        if (slot_end) begin
            num_out_d = (blank_lz && sel_blank) ? BLANK_CODE : sel_digit;
        end
    end

    // Anodes go dark on every slot change and light the current digit after the blank interval.
    always_comb begin
        anode_n_d = anode_n_q;
        if (slot_end) begin
            anode_n_d = '1;
        end
        if (lit_start) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                anode_n_d[k] = (index_d != IDX_W'(k));
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            active_q     <= '0;
            index_q      <= '0;
            num_out_q    <= BLANK_CODE;
            anode_n_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            index_q      <= index_d;
            num_out_q    <= num_out_d;
            anode_n_q    <= anode_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign num_out    = num_out_q;
    assign anode_n    = anode_n_q;
    assign frame_done = frame_done_q;

`ifndef SYNTHESIS
    // Two lit digits at once would short segment currents across digits.
    a_one_anode: assert property (@(posedge clk) disable iff (!rst_n) $countones(~anode_n_q) <= 1);
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: scoreboard of expected per-slot digit codes plus per-cycle anode/frame checks.
// Latency: slot codes compared at the first lit cycle and the last cycle of each slot.
// Backpressure: not applicable.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [4*ND-1:0] bcd_in;
    logic          blank_lz;
    logic [3:0]    num_out;
    logic [ND-1:0] anode_n;
    logic          frame_done;

    int            n_vec;
    int            n_err;
    int            cyc;
    logic [3:0]    exp_q[$];
    logic [3:0]    cur_exp;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .blank_lz   (blank_lz),
        .num_out    (num_out),
        .anode_n    (anode_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc=%0d t=%0t)", tag, got, want, cyc, $time);
        end
    endtask

    // Advance one clock, then check outputs against the cycle-position model.
    task automatic step();
        int         div;
        int         idx;
        logic [3:0] one;
        logic [3:0] exp_an;
        @(posedge clk);
        #1;
        cyc++;
        div    = cyc % RD;
        idx    = (cyc / RD) % ND;
        one    = 4'b0001 << idx;
        exp_an = (div < BC) ? 4'hF : ~one;
        chk("anode_n", 16'(anode_n), 16'(exp_an));
        chk("frame_done", 16'(frame_done), 16'((cyc % FRAME == 0) && (cyc != 0)));
        if (div == BC) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: got num_out %h expected none queued (cyc=%0d)", num_out, cyc);
            end else begin
                cur_exp = exp_q.pop_front();
                chk("num_out", 16'(num_out), 16'(cur_exp));
            end
        end
        if (div == RD - 1) begin
            chk("num_hold", 16'(num_out), 16'(cur_exp));
        end
    endtask

    // One full frame from a commit edge; codes packed digit 0 in the low nibble.
    task automatic run_frame(input logic [15:0] codes, input int ld_at, input logic [15:0] ld_val,
                             input int blz_at, input logic blz_val);
        for (int k = 0; k < ND; k++) begin
            exp_q.push_back(codes[4*k +: 4]);
        end
        for (int i = 0; i < FRAME; i++) begin
            load = (i == ld_at);
            if (i == ld_at) bcd_in = ld_val;
            if (i == blz_at) blank_lz = blz_val;
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        cur_exp  = 4'hF;
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_num_out", 16'(num_out), 16'h000F);
        chk("rst_anode_n", 16'(anode_n), 16'h000F);
        chk("rst_frame_done", 16'(frame_done), 16'h0000);
        rst_n = 1'b1;
        cyc   = 0;

        run_frame(16'h000F, -1, 16'h0000, -1, 1'b0);   // first slot blank, rest show zero
        run_frame(16'h0000, 13, 16'h1234, -1, 1'b0);   // mid-frame load held in shadow
        run_frame(16'h1234, 31, 16'h0987, -1, 1'b0);   // load on commit cycle bypasses shadow
        run_frame(16'h0987,  2, 16'h2468, -1, 1'b0);   // later load waits a frame
        run_frame(16'h2468,  5, 16'h0050,  5, 1'b1);   // enable blanking
        run_frame(16'hFF50,  7, 16'h0000, -1, 1'b0);
        run_frame(16'h00F0, -1, 16'h0000, 10, 1'b0);   // blank_lz drop mid-slot 1
        run_frame(16'h0000, 12, 16'hF0A0, 30, 1'b1);
        run_frame(16'hF0A0, 20, 16'h0405, -1, 1'b0);   // non-BCD passes through, none blanked
        run_frame(16'hF405, -1, 16'h0000, -1, 1'b0);   // interior zero kept

        // Partial frame, pending load, then asynchronous reset while a digit is lit.
        exp_q.push_back(4'h5);
        for (int i = 0; i < 5; i++) begin
            load = (i == 2);
            if (i == 2) bcd_in = 16'h9999;
            step();
        end
        load  = 1'b0;
        chk("pre_rst_anode_n", 16'(anode_n), 16'h000E);
        rst_n = 1'b0;
        #1;
        chk("async_num_out", 16'(num_out), 16'h000F);
        chk("async_anode_n", 16'(anode_n), 16'h000F);
        chk("async_frame_done", 16'(frame_done), 16'h0000);
        @(posedge clk);
        #1;
        blank_lz = 1'b0;
        rst_n    = 1'b1;
        cyc      = 0;
        run_frame(16'h000F, -1, 16'h0000, -1, 1'b0);
        run_frame(16'h0000, -1, 16'h0000, -1, 1'b0);   // pending shadow data was discarded

        chk("sb_drained", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
